// File: rtl/d_mem_responder.sv
// Memory-side responder for the data cache m_* interface: word RAM behind a fixed-latency handshake.
// Optional alignment checking and the m_err port are enabled by defining D_MEM_ALIGN_CHECK_EN.
module d_mem_responder #(
  parameter int A_WIDTH = 32,
  parameter int M_INDEX = 14,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  input  logic               m_rw,
  output logic               m_ready
`ifdef D_MEM_ALIGN_CHECK_EN
  ,
  output logic               m_err
`endif
);

  localparam int         DEPTH = 1 << M_INDEX;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [31:0]        ram_r [DEPTH];
  logic [1:0]         state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [M_INDEX-1:0] idx_r;
  logic [31:0]        din_r;
  logic [3:0]         wen_r;
  logic               rw_r;
  logic               err_r;
  logic               ready_r;
  logic [31:0]        dout_r;

  logic               accept_s;
  logic               enter_resp_s;
  logic               err_in_s;
  logic [M_INDEX-1:0] cur_idx_s;
  logic               cur_rw_s;
  logic               cur_err_s;

  // Address bits above the RAM index only alias; they are deliberately dropped.
  logic unused_hi_s;
  assign unused_hi_s = ^m_a[A_WIDTH-1:M_INDEX+2];

`ifdef D_MEM_ALIGN_CHECK_EN
  logic merr_r;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a_lo[0];
      default: misaligned = (a_lo != 2'b00);
    endcase
  endfunction

  // Alignment error of the request currently presented on the bus
  always_comb begin
    err_in_s = misaligned(m_size, m_a[1:0]);
  end

  assign m_err = merr_r;
`else
  logic unused_lo_s;
  assign unused_lo_s = ^{m_size, m_a[1:0]};

  // Alignment checking disabled: every request is treated as aligned
  always_comb begin
    err_in_s = 1'b0;
  end
`endif

  // Accept decode and request fields that apply on the edge entering RESP
  always_comb begin
    accept_s = (state_r == IDLE) && m_strobe;
    if (accept_s) begin
      cur_idx_s = m_a[M_INDEX+1:2];
      cur_rw_s  = m_rw;
      cur_err_s = err_in_s;
    end else begin
      cur_idx_s = idx_r;
      cur_rw_s  = rw_r;
      cur_err_s = err_r;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (m_strobe) begin
          cnt_s   = LAT;
          state_s = (LAT == 4'd0) ? RESP : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = RESP;
        end else begin
          state_s = BUSY;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    enter_resp_s = (state_s == RESP) && (state_r != RESP);
  end

  // FSM, request latches and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      din_r   <= 32'd0;
      wen_r   <= 4'd0;
      rw_r    <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b0;
      dout_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= enter_resp_s;
      if (accept_s) begin
        idx_r <= m_a[M_INDEX+1:2];
        din_r <= m_din;
        wen_r <= m_wen;
        rw_r  <= m_rw;
        err_r <= err_in_s;
      end
      // Read data is captured on the edge into RESP so it is valid with m_ready
      if (enter_resp_s && !cur_rw_s) begin
        dout_r <= cur_err_s ? 32'd0 : ram_r[cur_idx_s];
      end
    end
  end

`ifdef D_MEM_ALIGN_CHECK_EN
  // Error flag pulses alongside m_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      merr_r <= 1'b0;
    end else begin
      merr_r <= enter_resp_s && cur_err_s;
    end
  end
`endif

  // Byte-masked write commit on the edge that ends RESP; reset aborts it
  always_ff @(posedge clk) begin
    if (!rst && (state_r == RESP) && rw_r && !err_r) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_r[i]) begin
          ram_r[idx_r][8*i +: 8] <= din_r[8*i +: 8];
        end
      end
    end
  end

  assign m_ready = ready_r;
  assign m_dout  = dout_r;

endmodule
